multicycle_main_fsm: RTL and testbench

- Main control state machine for the multicycle RV32I core. It sits directly upstream of the ALU decoder and supplies the 2-bit alu_op it consumes.
- It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- It drives every datapath enable and mux select except alu_control.
- Memory accesses use a ready handshake so the core stalls on slow memory.

---
 rtl/multicycle_main_fsm.sv | 168 ++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type,
// I-type ALU, beq and jal, and drives every datapath enable and mux select
// except alu_control. Memory accesses stall on mem_ready.
module multicycle_main_fsm #(
    parameter int OP_W = 7,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            adr_src,
    output logic            mem_write,
    output logic            ir_write,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            reg_write,
    output logic [1:0]      alu_op,
    output logic            illegal_instr,
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = ST_W'(0),
        S_DECODE   = ST_W'(1),
        S_MEMADR   = ST_W'(2),
        S_MEMREAD  = ST_W'(3),
        S_MEMWB    = ST_W'(4),
        S_MEMWRITE = ST_W'(5),
        S_EXECUTER = ST_W'(6),
        S_EXECUTEI = ST_W'(7),
        S_ALUWB    = ST_W'(8),
        S_BEQ      = ST_W'(9),
        S_JAL      = ST_W'(10)
    } state_t;

    localparam logic [OP_W-1:0] OP_LW    = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_ITYPE = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(7'b1101111);

    state_t state_q;
    state_t state_d;

    // Raw (pre-reset-gating) enables produced by the state decode.
    logic pc_update;
    logic branch;
    logic mem_write_c;
    logic ir_write_c;
    logic reg_write_c;
    logic illegal_c;

    // State register: reset restarts the core at FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; ir_write/pc_update in FETCH and
    // illegal_instr in DECODE are the only input-dependent terms.
    always_comb begin
        state_d     = state_q;
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        reg_write_c = 1'b0;
        alu_op      = 2'b00;
        illegal_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut as the branch target
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables are forced low while reset is held so an in-flight write
    // strobe drops in the same cycle reset arrives.
    assign pc_write      = ~reset & (pc_update | (branch & zero));
    assign mem_write     = ~reset & mem_write_c;
    assign ir_write      = ~reset & ir_write_c;
    assign reg_write     = ~reset & reg_write_c;
    assign illegal_instr = ~reset & illegal_c;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Testbench for multicycle_main_fsm: instruction-level model builds the
// expected per-cycle output records, one compare process checks them.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] aop;
        logic       ill;
    } rec_t;

    rec_t exp_q[$];

    multicycle_main_fsm #(.OP_W(7), .ST_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .alu_op(alu_op),
        .illegal_instr(illegal_instr), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    function automatic rec_t mk(input int st, input bit pcw, input bit adr, input bit mw,
                                input bit irw, input int rs, input int sa, input int sb,
                                input bit rw, input int aop, input bit ill);
        rec_t r;
        r.st = 4'(st); r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw;
        r.rs = 2'(rs); r.sa = 2'(sa); r.sb = 2'(sb); r.rw = rw; r.aop = 2'(aop);
        r.ill = ill;
        return r;
    endfunction

    // One clock cycle: apply inputs just after the edge, queue what the
    // outputs must be for this cycle.
    task automatic cyc(input logic [6:0] o, input logic z, input logic mr, input rec_t r);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        op        = o;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(r);
    endtask

    // Instruction-level model: fetch (with fw wait cycles), decode, then the
    // steps for the opcode class; memory steps stall for mwt cycles.
    // n returns the instruction length excluding wait cycles.
    task automatic run_instr(input logic [6:0] o, input logic z, input int fw,
                             input int mwt, input logic mr_oth, output int n);
        bit legal;
        n = 0;
        for (int i = 0; i < fw; i++) cyc(o, z, 1'b0, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        cyc(o, z, 1'b1, mk(0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0)); n++;
        legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
        cyc(o, z, mr_oth, mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, !legal)); n++;
        case (o)
            7'b0000011: begin
                cyc(o, z, mr_oth, mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0)); n++;
                for (int i = 0; i < mwt; i++) cyc(o, z, 1'b0, mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                cyc(o, z, 1'b1, mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); n++;
                cyc(o, z, mr_oth, mk(4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0)); n++;
            end
            7'b0100011: begin
                cyc(o, z, mr_oth, mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0)); n++;
                for (int i = 0; i < mwt; i++) cyc(o, z, 1'b0, mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
                cyc(o, z, 1'b1, mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)); n++;
            end
            7'b0110011: begin
                cyc(o, z, mr_oth, mk(6, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0)); n++;
                cyc(o, z, mr_oth, mk(8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); n++;
            end
            7'b0010011: begin
                cyc(o, z, mr_oth, mk(7, 0, 0, 0, 0, 0, 2, 1, 0, 2, 0)); n++;
                cyc(o, z, mr_oth, mk(8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); n++;
            end
            7'b1100011: begin
                cyc(o, z, mr_oth, mk(9, z, 0, 0, 0, 0, 2, 0, 0, 1, 0)); n++;
            end
            7'b1101111: begin
                cyc(o, z, mr_oth, mk(10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0)); n++;
                cyc(o, z, mr_oth, mk(8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); n++;
            end
            default: ;
        endcase
    endtask

    // Single compare process: every queued cycle is checked mid-cycle.
    always @(negedge clk) begin
        rec_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state", int'(state), int'(e.st));
            chk("pc_write", int'(pc_write), int'(e.pcw));
            chk("adr_src", int'(adr_src), int'(e.adr));
            chk("mem_write", int'(mem_write), int'(e.mw));
            chk("ir_write", int'(ir_write), int'(e.irw));
            chk("result_src", int'(result_src), int'(e.rs));
            chk("alu_src_a", int'(alu_src_a), int'(e.sa));
            chk("alu_src_b", int'(alu_src_b), int'(e.sb));
            chk("reg_write", int'(reg_write), int'(e.rw));
            chk("alu_op", int'(alu_op), int'(e.aop));
            chk("illegal_instr", int'(illegal_instr), int'(e.ill));
        end
    end

    initial begin
        int n;
        reset = 1'b1; op = 7'b0; zero = 1'b0; mem_ready = 1'b1;
        // reset held for two cycles with mem_ready high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_state", int'(state), 0);
            chk("rst_ir_write", int'(ir_write), 0);
            chk("rst_pc_write", int'(pc_write), 0);
            chk("rst_mem_write", int'(mem_write), 0);
            chk("rst_alu_src_b", int'(alu_src_b), 2);
        end

        run_instr(7'b0000011, 1'b0, 0, 0, 1'b1, n); chk("cpi_lw", n, 5);
        run_instr(7'b0100011, 1'b1, 0, 3, 1'b0, n); chk("cpi_sw", n, 4);
        run_instr(7'b0110011, 1'b1, 0, 0, 1'b0, n); chk("cpi_r", n, 4);
        run_instr(7'b0010011, 1'b0, 0, 0, 1'b1, n); chk("cpi_i", n, 4);
        run_instr(7'b1100011, 1'b1, 0, 0, 1'b0, n); chk("cpi_beq_t", n, 3);
        run_instr(7'b1100011, 1'b0, 0, 0, 1'b1, n); chk("cpi_beq_nt", n, 3);
        run_instr(7'b1101111, 1'b0, 0, 0, 1'b0, n); chk("cpi_jal", n, 4);
        run_instr(7'b1111111, 1'b1, 0, 0, 1'b1, n); chk("cpi_illegal", n, 2);
        run_instr(7'b0000011, 1'b1, 2, 2, 1'b0, n); chk("cpi_lw_stall", n, 5);
        run_instr(7'b0100011, 1'b0, 0, 0, 1'b1, n); chk("cpi_sw_fast", n, 4);

        // sw stalled in MEMWRITE, then reset arrives mid-cycle
        cyc(7'b0100011, 1'b0, 1'b1, mk(0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
        cyc(7'b0100011, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        cyc(7'b0100011, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        cyc(7'b0100011, 1'b0, 1'b0, mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #2;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("midrst_mem_write", int'(mem_write), 0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_ir_write", int'(ir_write), 0);
        chk("midrst_pc_write", int'(pc_write), 0);
        chk("midrst_adr_src", int'(adr_src), 0);

        run_instr(7'b0110011, 1'b0, 1, 0, 1'b1, n); chk("cpi_r_after_rst", n, 4);
        cyc(7'b0000000, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
